div_seq: RTL
============

# div_seq

Sequential 32-bit radix-2 divider for the EX stage of the 5-stage MIPS pipeline. It produces the `divstall` signal that the hazard unit turns into `stallF`/`stallD`/`stallE`/`stallM`/`stallW`. It writes the quotient (LO) and remainder (HI) for DIV/DIVU. Each division is a one-cycle `start`, a `stall` window and a one-cycle `result_valid` completion pulse.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  a DIV/DIVU instruction is in EX. It stays high while EX is frozen.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `annul`  in  1  flush of EX (exception/eret). Cancels any division in progress.
- `a`  in  WIDTH  dividend (rs).
- `b`  in  WIDTH  divisor (rt).
- `stall`  out  1  to the hazard unit as `divstall`.
- `result_valid`  out  1  one-cycle pulse. `quotient`/`remainder` are valid in this cycle.
- `quotient`  out  WIDTH  LO write data.
- `remainder`  out  WIDTH  HI write data.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `start` is high and `annul` is low: latch `|a|`, `|b|`, the sign of `a` and the sign of `a` XOR the sign of `b`, go to BUSY, and clear the counter.
  - When `signed_div` is 0, magnitudes are the raw operands.
- **BUSY** performs one restoring step per cycle:
  - Shift `{rem, dvd}` left by 1.
  - If `rem >= divisor`, subtract the divisor and set the quotient LSB.
  - When the counter reaches `WIDTH-1`, go to DONE.
- **DONE**
  - Register the final results and assert `result_valid`.
  - Return to IDLE next cycle unconditionally.
  - `start` is still high in DONE (same instruction) and must not relaunch.
- **Sign fix-up**, applied when entering DONE and only in signed mode:
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives q = 0x80000000, r = 0.
- **Divide by zero** (`b == 0`), both modes: q = 0xFFFFFFFF, r = `a` unmodified.
- `quotient`/`remainder` hold their value until the next DONE.
- **`stall`** = `resetn` & !`annul` & ((IDLE & `start`) | BUSY). It is combinational so the pipeline freezes in the launch cycle.
- **`annul`** in any state:
  - Go to IDLE at the next edge.
  - `stall` is 0 that cycle and `result_valid` is not raised.
  - `quotient`/`remainder` are unchanged.

## Timing
- Launch cycle 0: IDLE with `start` = 1 and `stall` = 1.
- BUSY in cycles 1..32.
- DONE in cycle 33: `stall` = 0 and `result_valid` = 1.
- `stall` is high for exactly 33 cycles. Results are visible in cycle 33, when the pipeline advances.
- A back-to-back DIV in EX at cycle 34 launches immediately (state is IDLE).
- Reset values: state IDLE, counter 0, `quotient` 0, `remainder` 0, `result_valid` 0.
- While `resetn` is low, `stall` = 0 regardless of `start`.
- Reset mid-BUSY aborts at once and produces no completion pulse.
- `annul` and `start` high together in IDLE: no launch.
- `annul` high in DONE: `result_valid` is suppressed and the registers are not updated.

## Configuration
- Macro `DIV_ZERO_FAST_EN`.
- **Defined:**
  - IDLE with `start` and `b == 0` goes directly to DONE.
  - `stall` is high only in cycle 0.
  - `result_valid` fires in cycle 1 with q = 0xFFFFFFFF, r = `a`.
- **Undefined:**
  - Divide-by-zero runs the full 33-cycle stall with identical results.

## Test plan
- DIVU 100 / 7: `stall` is high for cycles 0..32. In cycle 33 `result_valid` = 1, q = 14, r = 2.
- DIV -7 / 2 (0xFFFFFFF9 / 2): q = 0xFFFFFFFD, r = 0xFFFFFFFF. DIV 7 / -2: q = 0xFFFFFFFD, r = 1.
- DIV 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0, with no extra cycles.
- DIVU 0x1234 / 0:
  - q = 0xFFFFFFFF, r = 0x1234.
  - Completion in cycle 1 with `DIV_ZERO_FAST_EN` defined, otherwise in cycle 33.
- `annul` at cycle 10 of a division: `stall` drops the same cycle and no `result_valid` follows. A new `start` at cycle 11 launches and completes 33 cycles later with correct results.
- `start` held high through DONE: exactly one `result_valid` pulse. `resetn` low at cycle 5: `stall` = 0, outputs 0, and no pulse afterwards.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider for the EX stage.
// Produces the pipeline stall (divstall), quotient (LO) and remainder (HI)
// for DIV/DIVU. Optional feature macro: DIV_ZERO_FAST_EN (a divide by zero
// completes one cycle after launch instead of running all iterations).
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, final remainder in DONE
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;   // raw dividend, remainder for divide by zero
  logic [WIDTH-1:0] quo_q, quo_d;     // held LO result
  logic [WIDTH-1:0] rmd_q, rmd_d;     // held HI result
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             launch;

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, dvsr_q};
    ge       = (rem_sh >= {1'b0, dvsr_q});
    rem_step = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], ge};
  end

  // Next-state and datapath updates; annul overrides everything to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    araw_d  = araw_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    launch  = start & ~annul;
    a_mag   = (signed_div & a[WIDTH-1]) ? -a : a;
    b_mag   = (signed_div & b[WIDTH-1]) ? -b : b;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          dvd_d   = a_mag;
          rem_d   = '0;
          dvsr_d  = b_mag;
          araw_d  = a;
          negq_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = signed_div & a[WIDTH-1];
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            dvd_d   = '1;
            rem_d   = a;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        // Final step folds in sign fix-up / divide-by-zero override so DONE
        // only has to present rem_q/dvd_q.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (dvsr_q == '0) begin
            dvd_d = '1;
            rem_d = araw_q;
          end else begin
            if (negq_q) dvd_d = -quo_step;
            if (negr_q) rem_d = -rem_step;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!annul) begin
          quo_d = dvd_q;
          rmd_d = rem_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (annul) state_d = S_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvsr_q  <= '0;
      araw_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      araw_q  <= araw_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Outputs: the new result is shown during the DONE cycle itself and is
  // latched into the held registers at its end, unless annulled.
  always_comb begin
    stall        = resetn & ~annul &
                   (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
    result_valid = (state_q == S_DONE) & ~annul;
    quotient     = result_valid ? dvd_q : quo_q;
    remainder    = result_valid ? rem_q : rmd_q;
  end

endmodule
